axi_lite_master_port: RTL and testbench
=======================================

// Module: axi_lite_master_port
// PURPOSE
//  AXI initiator for one CPU memory port (IM or DM side); the requesting end of the bus whose
//  responders sit behind the AXI bridge. Converts a simple core request (req/we/addr/wdata/wstrb)
//  into single-beat AXI read (AR->R) or write (AW+W->B) transactions. Stalls the core until the
//  response returns. Reports a non-OKAY response as an error pulse.
// PARAMETERS
//  MASTER_ID  default 4'd0  value driven on ARID_M/AWID_M (`AXI_ID_BITS wide)
// PORTS
//  clk        in   1                clock, rising edge
//  rst        in   1                async reset, active-low
//  req_i      in   1                core access request; held by the core while stall_o=1
//  we_i       in   1                1=write, 0=read; sampled with req_i
//  addr_i     in   `AXI_ADDR_BITS   byte address
//  wdata_i    in   `AXI_DATA_BITS   write data
//  wstrb_i    in   `AXI_STRB_BITS   byte enables, active-high
//  stall_o    out  1                core must hold its request/pipeline
//  done_o     out  1                one-cycle completion pulse
//  rdata_o    out  `AXI_DATA_BITS   read data; valid from done_o until the next read completes
//  err_o      out  1                one-cycle pulse with done_o if RRESP/BRESP != OKAY
//  ARID_M,ARADDR_M,ARLEN_M,ARSIZE_M,ARBURST_M,ARVALID_M  out; ARREADY_M in   read address channel
//  RID_M,RDATA_M,RRESP_M,RLAST_M,RVALID_M in;  RREADY_M out                   read data channel
//  AWID_M,AWADDR_M,AWLEN_M,AWSIZE_M,AWBURST_M,AWVALID_M out; AWREADY_M in  write address channel
//  WDATA_M,WSTRB_M,WLAST_M,WVALID_M out; WREADY_M in                           write data channel
//  BID_M,BRESP_M,BVALID_M in; BREADY_M out                                     write response
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE; all VALID/READY outputs 0; done_o=err_o=0; rdata_o=0;
//   address/data registers 0. Reset mid-transaction aborts it immediately; no completion reported.
//  Fixed fields: ARLEN/AWLEN=0, ARSIZE/AWSIZE=3'b010, ARBURST/AWBURST=2'b01 (INCR), WLAST_M=1
//   whenever WVALID_M=1. ARID/AWID=MASTER_ID.
//  stall_o = req_i & ~done_o: high combinationally on the request cycle, low on the done cycle.
//  FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDRDATA, WR_RESP.
//   IDLE: req_i=1 latches addr/wdata/wstrb/we; next RD_ADDR (we=0) or WR_ADDRDATA (we=1).
//    Earliest ARVALID/AWVALID is the cycle after req_i.
//   RD_ADDR: ARVALID_M=1, ARADDR stable until ARREADY_M; on handshake -> RD_DATA.
//   RD_DATA: RREADY_M=1. The first accepted beat's RDATA/RRESP are captured. Exit on RVALID&RLAST ->
//    IDLE with done_o=1 in that cycle, rdata_o=RDATA_M registered, err_o=(RRESP!=2'b00).
//    Extra beats with RLAST=0 are accepted and discarded (tolerates a misbehaving responder).
//   WR_ADDRDATA: AWVALID_M and WVALID_M rise together. Each drops independently after its own
//    handshake (aw_done/w_done flags); both in the same cycle is legal. When both are done -> WR_RESP.
//   WR_RESP: BREADY_M=1; on BVALID -> IDLE, done_o=1, err_o=(BRESP!=2'b00).
//  Back-to-back: after done_o, the core may assert a new request in the next cycle. Requests in a
//   non-IDLE state are not resampled; the latched request is used.
//  VALID never depends on READY. Once asserted, VALID stays high with stable payload until the handshake.
//  RID/BID are ignored; one outstanding transaction only.
// TESTING
//  1 read, ARREADY=1 in the same cycle, RDATA=32'hDEADBEEF RRESP=OKAY RLAST=1 next cycle
//    -> done_o 3 cycles after req_i, rdata_o=DEADBEEF, err_o=0.
//  2 write addr=32'h1000_0004 wstrb=4'b0011; AWREADY 2 cycles late, WREADY immediately
//    -> WVALID drops first, AWVALID holds until its handshake, then BREADY; done_o on BVALID.
//  3 read to an unmapped address, responder returns RRESP=DECERR(2'b11)
//    -> done_o=1 with err_o=1, rdata_o=0.
//  4 ARREADY held low 10 cycles -> ARVALID/ARADDR stable all 10 cycles, stall_o=1 throughout.
//  5 rst=0 asserted while in WR_ADDRDATA -> AWVALID/WVALID=0 same cycle, state IDLE, no done_o.
//  6 responder returns 2 beats (RLAST=0 then 1) -> first beat data in rdata_o, single done_o on RLAST.

Source files
------------

// File: rtl/axi_lite_master_port.sv
// axi_lite_master_port: single-beat AXI initiator that turns a core load/store request into an AR/R or AW+W/B exchange
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module axi_lite_master_port #(
  parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [`AXI_ADDR_BITS-1:0]  addr_i,
  input  logic [`AXI_DATA_BITS-1:0]  wdata_i,
  input  logic [`AXI_STRB_BITS-1:0]  wstrb_i,
  output logic                       stall_o,
  output logic                       done_o,
  output logic [`AXI_DATA_BITS-1:0]  rdata_o,
  output logic                       err_o,
  output logic [`AXI_ID_BITS-1:0]    ARID_M,
  output logic [`AXI_ADDR_BITS-1:0]  ARADDR_M,
  output logic [`AXI_LEN_BITS-1:0]   ARLEN_M,
  output logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M,
  output logic [1:0]                 ARBURST_M,
  output logic                       ARVALID_M,
  input  logic                       ARREADY_M,
  input  logic [`AXI_ID_BITS-1:0]    RID_M,
  input  logic [`AXI_DATA_BITS-1:0]  RDATA_M,
  input  logic [1:0]                 RRESP_M,
  input  logic                       RLAST_M,
  input  logic                       RVALID_M,
  output logic                       RREADY_M,
  output logic [`AXI_ID_BITS-1:0]    AWID_M,
  output logic [`AXI_ADDR_BITS-1:0]  AWADDR_M,
  output logic [`AXI_LEN_BITS-1:0]   AWLEN_M,
  output logic [`AXI_SIZE_BITS-1:0]  AWSIZE_M,
  output logic [1:0]                 AWBURST_M,
  output logic                       AWVALID_M,
  input  logic                       AWREADY_M,
  output logic [`AXI_DATA_BITS-1:0]  WDATA_M,
  output logic [`AXI_STRB_BITS-1:0]  WSTRB_M,
  output logic                       WLAST_M,
  output logic                       WVALID_M,
  input  logic                       WREADY_M,
  input  logic [`AXI_ID_BITS-1:0]    BID_M,
  input  logic [1:0]                 BRESP_M,
  input  logic                       BVALID_M,
  output logic                       BREADY_M
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDRDATA, WR_RESP} state_t;
  state_t                     state;
  logic [`AXI_ADDR_BITS-1:0]  addr_q;
  logic [`AXI_DATA_BITS-1:0]  wdata_q;
  logic [`AXI_STRB_BITS-1:0]  wstrb_q;
  logic [`AXI_DATA_BITS-1:0]  beat_data;
  logic [1:0]                 beat_resp;
  logic                       got_beat;
  logic                       unused_ids;
  assign unused_ids = ^{RID_M, BID_M};
  assign stall_o   = req_i & ~done_o;
  assign ARID_M    = MASTER_ID;
  assign AWID_M    = MASTER_ID;
  assign ARADDR_M  = addr_q;
  assign AWADDR_M  = addr_q;
  assign ARLEN_M   = '0;
  assign AWLEN_M   = '0;
  assign ARSIZE_M  = 3'b010;
  assign AWSIZE_M  = 3'b010;
  assign ARBURST_M = 2'b01;
  assign AWBURST_M = 2'b01;
  assign WDATA_M   = wdata_q;
  assign WSTRB_M   = wstrb_q;
  assign WLAST_M   = 1'b1;
  // Transaction FSM; the done cycle still sees the old req_i, so a new request is only taken once done_o is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      beat_data <= '0;
      beat_resp <= '0;
      got_beat  <= 1'b0;
      ARVALID_M <= 1'b0;
      RREADY_M  <= 1'b0;
      AWVALID_M <= 1'b0;
      WVALID_M  <= 1'b0;
      BREADY_M  <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: if (req_i && !done_o) begin
          addr_q   <= addr_i;
          wdata_q  <= wdata_i;
          wstrb_q  <= wstrb_i;
          got_beat <= 1'b0;
          if (we_i) begin
            state     <= WR_ADDRDATA;
            AWVALID_M <= 1'b1;
            WVALID_M  <= 1'b1;
          end else begin
            state     <= RD_ADDR;
            ARVALID_M <= 1'b1;
          end
        end
        RD_ADDR: if (ARREADY_M) begin
          ARVALID_M <= 1'b0;
          RREADY_M  <= 1'b1;
          state     <= RD_DATA;
        end
        RD_DATA: if (RVALID_M) begin
          if (!got_beat) begin
            got_beat  <= 1'b1;
            beat_data <= RDATA_M;
            beat_resp <= RRESP_M;
          end
          if (RLAST_M) begin
            RREADY_M <= 1'b0;
            done_o   <= 1'b1;
            rdata_o  <= got_beat ? beat_data : RDATA_M;
            err_o    <= (got_beat ? beat_resp : RRESP_M) != 2'b00;
            state    <= IDLE;
          end
        end
        WR_ADDRDATA: begin
          if (AWREADY_M) AWVALID_M <= 1'b0;
          if (WREADY_M) WVALID_M <= 1'b0;
          if ((!AWVALID_M || AWREADY_M) && (!WVALID_M || WREADY_M)) begin
            BREADY_M <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: if (BVALID_M) begin
          BREADY_M <= 1'b0;
          done_o   <= 1'b1;
          err_o    <= BRESP_M != 2'b00;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_master_port.sv
// tb_axi_lite_master_port: directed plus randomized transactions against a cycle-timing reference model
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module tb_axi_lite_master_port;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [3:0]  wstrb_i = '0;
  logic        stall_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic [3:0]  ARID_M, AWID_M, RID_M = '0, BID_M = '0;
  logic [31:0] ARADDR_M, AWADDR_M, RDATA_M = '0, WDATA_M;
  logic [3:0]  ARLEN_M, AWLEN_M, WSTRB_M;
  logic [2:0]  ARSIZE_M, AWSIZE_M;
  logic [1:0]  ARBURST_M, AWBURST_M, RRESP_M = '0, BRESP_M = '0;
  logic        ARVALID_M, ARREADY_M = 1'b0, RLAST_M = 1'b0, RVALID_M = 1'b0, RREADY_M;
  logic        AWVALID_M, AWREADY_M = 1'b0, WLAST_M, WVALID_M, WREADY_M = 1'b0;
  logic        BVALID_M = 1'b0, BREADY_M;
  int          n_checks = 0, n_fail = 0;
  logic [31:0] last_rdata = '0;
  logic [31:0] bdata [4];
  logic [1:0]  brsp [4];

  axi_lite_master_port #(.MASTER_ID(4'd5)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .wstrb_i(wstrb_i), .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
    .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
    .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
    .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
    .WREADY_M(WREADY_M), .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M),
    .BREADY_M(BREADY_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One core request from the cycle it is raised (c=0) through its done cycle; the responder and the
  // expected bus activity both come from the handshake delays: a READY arriving d cycles after VALID
  // rises at c=1 completes at c=1+d, the response phase starts the cycle after, done follows its last beat.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input int ad, input int awd, input int wdd, input int rd, input int bd,
                     input int nb, input logic [1:0] bresp);
    int m, lat, rs, k;
    logic e;
    m   = awd > wdd ? awd : wdd;
    lat = w ? 3 + m + bd : 2 + ad + rd + nb;
    rs  = 2 + ad + rd;
    e   = w ? (bresp != 2'b00) : (brsp[0] != 2'b00);
    for (int c = 0; c <= lat; c++) begin
      if (c == 0) begin
        req_i = 1'b1; we_i = w; addr_i = a; wdata_i = wd; wstrb_i = ws;
      end
      k         = c - rs;
      ARREADY_M = !w && c == 1 + ad;
      RVALID_M  = !w && c >= rs && c < rs + nb;
      RDATA_M   = RVALID_M ? bdata[k] : $urandom;
      RRESP_M   = RVALID_M ? brsp[k] : 2'($urandom);
      RLAST_M   = RVALID_M ? (k == nb - 1) : 1'($urandom);
      AWREADY_M = w && c == 1 + awd;
      WREADY_M  = w && c == 1 + wdd;
      BVALID_M  = w && c == lat - 1;
      BRESP_M   = bresp;
      #1;
      chk("done", done_o, c == lat);
      chk("stall", stall_o, c != lat);
      chk("err", err_o, c == lat && e);
      chk("rdata", rdata_o, (c == lat && !w) ? bdata[0] : last_rdata);
      chk("arvalid", ARVALID_M, !w && c >= 1 && c <= 1 + ad);
      chk("rready", RREADY_M, !w && c >= 2 + ad && c < lat);
      chk("awvalid", AWVALID_M, w && c >= 1 && c <= 1 + awd);
      chk("wvalid", WVALID_M, w && c >= 1 && c <= 1 + wdd);
      chk("bready", BREADY_M, w && c >= 2 + m && c < lat);
      if (!w && c >= 1 && c <= 1 + ad) begin
        chk("araddr", ARADDR_M, a);
        chk("ar_fixed", {ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M}, {4'd5, 4'd0, 3'b010, 2'b01});
      end
      if (w && c >= 1 && c <= 1 + awd) begin
        chk("awaddr", AWADDR_M, a);
        chk("aw_fixed", {AWID_M, AWLEN_M, AWSIZE_M, AWBURST_M}, {4'd5, 4'd0, 3'b010, 2'b01});
      end
      if (w && c >= 1 && c <= 1 + wdd) begin
        chk("wdata", WDATA_M, wd);
        chk("wstrb", WSTRB_M, ws);
        chk("wlast", WLAST_M, 1'b1);
      end
      @(posedge clk);
      #1;
    end
    if (!w) last_rdata = bdata[0];
    ARREADY_M = 1'b0; RVALID_M = 1'b0; AWREADY_M = 1'b0; WREADY_M = 1'b0; BVALID_M = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_valids", {ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M}, 5'b0);
    chk("rst_done_err", {done_o, err_o}, 2'b0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_addr", ARADDR_M, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_stall", stall_o, 1'b0);
    bdata[0] = 32'hDEADBEEF; brsp[0] = 2'b00;
    txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1, 2'b00);
    txn(1'b1, 32'h1000_0004, 32'hCAFE_1234, 4'b0011, 0, 2, 0, 0, 1, 1, 2'b00);
    bdata[0] = 32'h0; brsp[0] = 2'b11;
    txn(1'b0, 32'hF000_0000, 32'h0, 4'h0, 0, 0, 0, 1, 0, 1, 2'b00);
    bdata[0] = 32'h1234_5678; brsp[0] = 2'b00;
    txn(1'b0, 32'h0000_2008, 32'h0, 4'h0, 10, 0, 0, 0, 0, 1, 2'b00);
    bdata[0] = 32'hAAAA_0001; brsp[0] = 2'b00; bdata[1] = 32'hBBBB_0002; brsp[1] = 2'b10;
    txn(1'b0, 32'h0000_3000, 32'h0, 4'h0, 1, 0, 0, 2, 0, 2, 2'b00);
    txn(1'b1, 32'h0000_4000, 32'h5555_AAAA, 4'b1111, 0, 1, 1, 0, 0, 1, 2'b10);
    txn(1'b1, 32'h0000_4004, 32'h0F0F_0F0F, 4'b1000, 0, 0, 3, 0, 2, 1, 2'b00);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_5000; wdata_i = 32'h7777_7777; wstrb_i = 4'hF;
    @(posedge clk); #1;
    chk("pre_rst_awvalid", {AWVALID_M, WVALID_M}, 2'b11);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_valids", {AWVALID_M, WVALID_M, BREADY_M}, 3'b0);
    chk("rst_mid_done", done_o, 1'b0);
    chk("rst_mid_rdata", rdata_o, 32'h0);
    req_i = 1'b0;
    last_rdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", {done_o, err_o, ARVALID_M, AWVALID_M, WVALID_M, stall_o}, 6'b0);
    end
    bdata[0] = 32'h0BAD_F00D; brsp[0] = 2'b00;
    txn(1'b0, 32'h0000_6000, 32'h0, 4'h0, 2, 0, 0, 1, 0, 1, 2'b00);
    for (int t = 0; t < 40; t++) begin
      logic w;
      int nb;
      w  = 1'($urandom);
      nb = $urandom_range(1, 3);
      for (int b = 0; b < 4; b++) begin
        bdata[b] = $urandom;
        brsp[b]  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      end
      txn(w, $urandom, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), nb,
          ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
      if (t % 7 == 6) begin
        req_i = 1'b0;
        @(posedge clk); #1;
        chk("gap_idle", {done_o, ARVALID_M, AWVALID_M, stall_o}, 4'b0);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
